// File: rtl/kernel_merge2.sv
// Two-input to one-output stream merge: strict round-robin bursts of BURST words, A first.
// Optional MERGE2_MISMATCH_EN adds a lockstep comparator counting B words that differ from last A.
module kernel_merge2 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BURST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] input_S1,
  input  logic                    avail_S1,
  output logic                    read_S1,
  input  logic signed [WIDTH-1:0] input_S2,
  input  logic                    avail_S2,
  output logic                    read_S2,
  output logic signed [WIDTH-1:0] output_S3,
  output logic                    write_S3,
  input  logic                    full_S3,
  output logic                    running
`ifdef MERGE2_MISMATCH_EN
  ,
  output logic [15:0]             mismatch_count
`endif
);

  typedef enum logic [2:0] {
    StReadA  = 3'd1,
    StWriteA = 3'd2,
    StReadB  = 3'd3,
    StWriteB = 3'd4
  } state_e;

  localparam logic [7:0] BurstLast = 8'(BURST - 1);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] hold_q, hold_d;
  logic [7:0]              bcnt_q, bcnt_d;
  logic                    running_q, running_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReadA;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      bcnt_q    <= '0;
      running_q <= 1'b1;
    end else begin
      hold_q    <= hold_d;
      bcnt_q    <= bcnt_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    bcnt_d    = bcnt_q;
    running_d = 1'b1;
    case (state_q)
      StReadA: begin
        running_d = avail_S1;
        if (avail_S1) begin
          hold_d  = input_S1;
          state_d = StWriteA;
        end
      end
      StWriteA: begin
        // Burst switch happens on the write of the last word, not on its read.
        if (!full_S3) begin
          if (bcnt_q == BurstLast) begin
            bcnt_d  = '0;
            state_d = StReadB;
          end else begin
            bcnt_d  = bcnt_q + 8'd1;
            state_d = StReadA;
          end
        end
      end
      StReadB: begin
        running_d = avail_S2;
        if (avail_S2) begin
          hold_d  = input_S2;
          state_d = StWriteB;
        end
      end
      StWriteB: begin
        if (!full_S3) begin
          if (bcnt_q == BurstLast) begin
            bcnt_d  = '0;
            state_d = StReadA;
          end else begin
            bcnt_d  = bcnt_q + 8'd1;
            state_d = StReadB;
          end
        end
      end
      default: state_d = StReadA;
    endcase
  end

  always_comb begin
    read_S1   = (state_q == StReadA) && avail_S1;
    read_S2   = (state_q == StReadB) && avail_S2;
    write_S3  = ((state_q == StWriteA) || (state_q == StWriteB)) && !full_S3;
    output_S3 = hold_q;
    running   = running_q;
  end

`ifdef MERGE2_MISMATCH_EN
  logic signed [WIDTH-1:0] last_a_q;
  logic [15:0]             mismatch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_a_q   <= '0;
      mismatch_q <= '0;
    end else begin
      if (read_S1) begin
        last_a_q <= input_S1;
      end
      if (read_S2 && (input_S2 != last_a_q) && (mismatch_q != 16'hFFFF)) begin
        mismatch_q <= mismatch_q + 16'd1;
      end
    end
  end

  assign mismatch_count = mismatch_q;
`endif

endmodule
